// File: rtl/arith_arb_if.sv
// Requester/arbiter bundle for arith_arb: two req/gnt operand ports plus the shared result and done pulses.
// Master drives requests and operands; slave is the arbiter.
interface arith_arb_if #(
    parameter int WIDTH = 8
);
    logic             req0;
    logic [WIDTH-1:0] a0;
    logic [WIDTH-1:0] b0;
    logic             sub0;
    logic             req1;
    logic [WIDTH-1:0] a1;
    logic [WIDTH-1:0] b1;
    logic             sub1;
    logic             gnt0;
    logic             gnt1;
    logic             done0;
    logic             done1;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             ov;
    logic             busy;

    modport master (
        output req0, a0, b0, sub0, req1, a1, b1, sub1,
        input  gnt0, gnt1, done0, done1, result, cout, ov, busy
    );

    modport slave (
        input  req0, a0, b0, sub0, req1, a1, b1, sub1,
        output gnt0, gnt1, done0, done1, result, cout, ov, busy
    );
endinterface

// File: rtl/arith_arb.sv
// Round-robin arbiter sharing one add/sub datapath between two requesters; ARITH_ARB_SAT_EN saturates on overflow.
// Latency: gnt one edge after req, done two edges after gnt; one operation per 3 cycles, req ignored while busy.
// Backpressure: a requester holds req and operands until gnt; nothing is queued.
module arith_arb #(
    parameter int WIDTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    arith_arb_if.slave  bus
);
    localparam int MSB = WIDTH - 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic             grant_en;
    logic             winner;
    logic             owner;
    logic             last_served;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             op_sub;

    logic             gnt0_q;
    logic             gnt1_q;
    logic             done0_q;
    logic             done1_q;
    logic [WIDTH-1:0] result_q;
    logic             cout_q;
    logic             ov_q;

    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   sum_ext;
    logic [WIDTH-1:0] sum_res;
    logic [WIDTH-1:0] res_final;
    logic             ov_calc;

    // Subtraction is a + ~b + 1, so cout=1 means no borrow.
    always_comb begin
        b_eff   = op_sub ? ~op_b : op_b;
        sum_ext = {1'b0, op_a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, op_sub};
        sum_res = sum_ext[MSB:0];
        if (op_sub) begin
            ov_calc = (op_a[MSB] != op_b[MSB]) && (sum_res[MSB] != op_a[MSB]);
        end else begin
            ov_calc = (op_a[MSB] == op_b[MSB]) && (sum_res[MSB] != op_a[MSB]);
        end
    end

`ifdef ARITH_ARB_SAT_EN
    // Overflow direction follows the sign of a: negative a can only underflow.
    always_comb begin
        res_final = sum_res;
        if (ov_calc) begin
            res_final = op_a[MSB] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
    end
`else
    always_comb begin
        res_final = sum_res;
    end
`endif

    always_comb begin
        state_nxt = state;
        grant_en  = 1'b0;
        winner    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.req0 || bus.req1) begin
                    grant_en  = 1'b1;
                    state_nxt = EXEC;
                    if (bus.req0 && bus.req1) begin
                        winner = ~last_served;
                    end else begin
                        winner = bus.req1;
                    end
                end
            end
            EXEC:    state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // last_served resets to 1 so a tie after reset goes to requester 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            gnt0_q      <= 1'b0;
            gnt1_q      <= 1'b0;
            done0_q     <= 1'b0;
            done1_q     <= 1'b0;
            result_q    <= '0;
            cout_q      <= 1'b0;
            ov_q        <= 1'b0;
            owner       <= 1'b0;
            last_served <= 1'b1;
            op_a        <= '0;
            op_b        <= '0;
            op_sub      <= 1'b0;
        end else begin
            gnt0_q  <= grant_en && !winner;
            gnt1_q  <= grant_en && winner;
            done0_q <= (state == DONE) && !owner;
            done1_q <= (state == DONE) && owner;
            if (grant_en) begin
                owner       <= winner;
                last_served <= winner;
                op_a        <= winner ? bus.a1   : bus.a0;
                op_b        <= winner ? bus.b1   : bus.b0;
                op_sub      <= winner ? bus.sub1 : bus.sub0;
            end
            if (state == EXEC) begin
                result_q <= res_final;
                cout_q   <= sum_ext[WIDTH];
                ov_q     <= ov_calc;
            end
        end
    end

    assign bus.gnt0   = gnt0_q;
    assign bus.gnt1   = gnt1_q;
    assign bus.done0  = done0_q;
    assign bus.done1  = done1_q;
    assign bus.result = result_q;
    assign bus.cout   = cout_q;
    assign bus.ov     = ov_q;
    assign bus.busy   = (state != IDLE);
endmodule

// File: tb/tb_arith_arb.sv
// Scoreboard bench for arith_arb: stimulus queues expected grants/results, a monitor compares on gnt/done.
module tb_arith_arb;
    localparam int WIDTH = 8;

    typedef struct {
        bit         who;
        logic [7:0] res;
        logic       c;
        logic       v;
    } exp_t;

    logic clk;
    logic rst;
    int   tests;
    int   errors;
    bit   mon_on;
    bit   grant_q[$];
    exp_t res_q[$];

    arith_arb_if #(.WIDTH(WIDTH)) bus ();

    arith_arb #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic expect_op(input bit who, input logic [7:0] res, input logic c, input logic v);
        exp_t e;
        e.who = who;
        e.res = res;
        e.c   = c;
        e.v   = v;
        grant_q.push_back(who);
        res_q.push_back(e);
    endtask

    // Waits for gnt then done, checking the 1-cycle and 2-cycle latencies.
    task automatic wait_gnt_done();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(bus.gnt0 || bus.gnt1) && n < 8);
        check("gnt_latency", n, 1);
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(bus.done0 || bus.done1) && n < 8);
        check("done_latency", n, 2);
    endtask

    task automatic run_op(input bit who, input logic [7:0] a, input logic [7:0] b, input bit s,
                          input logic [7:0] res, input logic c, input logic v);
        expect_op(who, res, c, v);
        @(negedge clk);
        if (!who) begin
            bus.req0 = 1'b1; bus.a0 = a; bus.b0 = b; bus.sub0 = s;
        end else begin
            bus.req1 = 1'b1; bus.a1 = a; bus.b1 = b; bus.sub1 = s;
        end
        wait_gnt_done();
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a grant or a done pulse.
    always @(negedge clk) begin
        if (mon_on) begin
            if (bus.gnt0 || bus.gnt1) begin
                check("gnt_onehot", bus.gnt0 & bus.gnt1, 0);
                check("gnt_expected", grant_q.size() > 0, 1);
                if (grant_q.size() > 0) check("gnt_who", bus.gnt1, grant_q.pop_front());
            end
            if (bus.done0 || bus.done1) begin
                check("done_onehot", bus.done0 & bus.done1, 0);
                check("done_expected", res_q.size() > 0, 1);
                if (res_q.size() > 0) begin
                    exp_t e;
                    e = res_q.pop_front();
                    check("done_who", bus.done1, e.who);
                    check("result", bus.result, e.res);
                    check("cout", bus.cout, e.c);
                    check("ov", bus.ov, e.v);
                end
            end
        end
    end

    initial begin
        int g;
        int cyc;
        tests  = 0;
        errors = 0;
        mon_on = 1'b0;
        rst    = 1'b1;
        bus.req0 = 1'b0; bus.a0 = '0; bus.b0 = '0; bus.sub0 = 1'b0;
        bus.req1 = 1'b0; bus.a1 = '0; bus.b1 = '0; bus.sub1 = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset_outputs",
              {bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.busy, bus.cout, bus.ov, bus.result}, 0);
        mon_on = 1'b1;

        run_op(1'b0, 8'hA5, 8'h5A, 1'b0, 8'hFF, 1'b0, 1'b0);
        run_op(1'b1, 8'hFF, 8'h02, 1'b1, 8'hFD, 1'b1, 1'b0);

        // Both requesters held: pointer last served 1, so grants run 0,1,0,1.
        expect_op(1'b0, 8'h22, 1'b0, 1'b0);
        expect_op(1'b1, 8'h00, 1'b1, 1'b0);
        expect_op(1'b0, 8'h22, 1'b0, 1'b0);
        expect_op(1'b1, 8'h00, 1'b1, 1'b0);
        @(negedge clk);
        bus.req0 = 1'b1; bus.a0 = 8'h11; bus.b0 = 8'h11; bus.sub0 = 1'b0;
        bus.req1 = 1'b1; bus.a1 = 8'h01; bus.b1 = 8'h01; bus.sub1 = 1'b1;
        g = 0;
        cyc = 0;
        while (g < 4 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (bus.gnt0 || bus.gnt1) g++;
        end
        check("concurrent_grants", g, 4);
        check("concurrent_cycles", cyc, 10);
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        repeat (4) @(negedge clk);

`ifdef ARITH_ARB_SAT_EN
        run_op(1'b0, 8'h7F, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);
        run_op(1'b0, 8'h80, 8'h01, 1'b1, 8'h80, 1'b1, 1'b1);
`else
        run_op(1'b0, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
        run_op(1'b0, 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1);
`endif

        // Reset while in EXEC: grant expected, no done.
        grant_q.push_back(1'b0);
        @(negedge clk);
        bus.req0 = 1'b1; bus.a0 = 8'h01; bus.b0 = 8'h01; bus.sub0 = 1'b0;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!bus.gnt0 && cyc < 8);
        check("abort_gnt_latency", cyc, 1);
        bus.req0 = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_outputs",
              {bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.busy, bus.cout, bus.ov, bus.result}, 0);
        repeat (4) @(negedge clk);
        check("abort_idle", bus.busy, 0);

        // Tie right after reset must go to requester 0.
        expect_op(1'b0, 8'h22, 1'b0, 1'b0);
        @(negedge clk);
        bus.req0 = 1'b1; bus.a0 = 8'h11; bus.b0 = 8'h11; bus.sub0 = 1'b0;
        bus.req1 = 1'b1; bus.a1 = 8'h01; bus.b1 = 8'h01; bus.sub1 = 1'b1;
        wait_gnt_done();

        run_op(1'b1, 8'h10, 8'h03, 1'b1, 8'h0D, 1'b1, 1'b0);

        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle_ctrl", {bus.busy, bus.gnt0, bus.gnt1, bus.done0, bus.done1}, 0);
        end
        check("idle_hold", {bus.result, bus.cout, bus.ov}, {8'h0D, 1'b1, 1'b0});

        repeat (3) @(negedge clk);
        check("grant_q_empty", grant_q.size(), 0);
        check("res_q_empty", res_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end
endmodule
